// File: rtl/decoder_3to8_scan.sv
// 3-to-8 one-hot decoder with pushbutton capture, BCD capture count and a
// 4-digit multiplexed seven-segment scan. Optional macro: DEBOUNCE_EN.
module decoder_3to8_scan #(
  parameter int unsigned REFRESH_DIV     = 100000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] din,
  input  logic       en,
  input  logic       load,
  output logic [7:0] dout,
  output logic       valid,
  output logic [7:0] segments,
  output logic [3:0] anodes
);

  localparam int unsigned RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  if (REFRESH_DIV < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("decoder_3to8_scan: REFRESH_DIV must be >= 2 and DEBOUNCE_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    DIG_CODE  = 2'd0,
    DIG_BLANK = 2'd1,
    DIG_ONES  = 2'd2,
    DIG_TENS  = 2'd3
  } digit_t;

  logic          s1, s2, s3;
  logic          level;
  logic          rise;
  logic [2:0]    code_reg;
  logic [3:0]    ones, tens;
  digit_t        digit, digit_next;
  logic [RW-1:0] refresh, refresh_next;
  logic [3:0]    anodes_next;
  logic [7:0]    segments_next;

  function automatic logic [7:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

`ifdef DEBOUNCE_EN
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [DW-1:0] stable_cnt;
  logic          deb;

  // deb follows s2 only after s2 has differed from it for DEBOUNCE_CYCLES samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_cnt <= '0;
      deb        <= 1'b0;
    end else if (s2 != deb) begin
      if (stable_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        deb        <= s2;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end else begin
      stable_cnt <= '0;
    end
  end

  assign level = deb;
`else
  assign level = s2;
`endif

  assign rise = level & ~s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      code_reg <= '0;
      dout     <= '0;
      valid    <= 1'b0;
      ones     <= '0;
      tens     <= '0;
    end else begin
      s1    <= load;
      s2    <= s1;
      s3    <= level;
      valid <= 1'b0;
      if (rise && en) begin
        code_reg <= din;
        dout     <= 8'd1 << din;
        valid    <= 1'b1;
        if (ones == 4'd9) begin
          ones <= '0;
          tens <= (tens == 4'd9) ? 4'd0 : tens + 4'd1;
        end else begin
          ones <= ones + 4'd1;
        end
      end else begin
        dout <= en ? (8'd1 << code_reg) : '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit    <= DIG_CODE;
      refresh  <= '0;
      anodes   <= 4'b1110;
      segments <= 8'hC0;
    end else begin
      digit    <= digit_next;
      refresh  <= refresh_next;
      anodes   <= anodes_next;
      segments <= segments_next;
    end
  end

  // Outputs are decoded from the next digit so anodes and segments switch together
  always_comb begin
    refresh_next  = refresh + 1'b1;
    digit_next    = digit;
    anodes_next   = 4'b1110;
    segments_next = 8'hFF;
    if (refresh == RW'(REFRESH_DIV - 1)) begin
      refresh_next = '0;
      case (digit)
        DIG_CODE:  digit_next = DIG_BLANK;
        DIG_BLANK: digit_next = DIG_ONES;
        DIG_ONES:  digit_next = DIG_TENS;
        default:   digit_next = DIG_CODE;
      endcase
    end
    case (digit_next)
      DIG_CODE: begin
        anodes_next   = 4'b1110;
        segments_next = seg7({1'b0, code_reg});
      end
      DIG_BLANK: begin
        anodes_next   = 4'b1101;
        segments_next = 8'hFF;
      end
      DIG_ONES: begin
        anodes_next   = 4'b1011;
        segments_next = seg7(ones);
      end
      default: begin
        anodes_next   = 4'b0111;
        segments_next = seg7(tens);
      end
    endcase
  end

endmodule

// File: tb/tb_decoder_3to8_scan.sv
// Randomized self-checking bench for decoder_3to8_scan against a behavioural
// model (capture code, capture count 0..99, scan position from cycle count).
module tb_decoder_3to8_scan;

  localparam int unsigned RDIV = 4;
`ifdef DEBOUNCE_EN
  localparam int unsigned DB = 8;
`else
  localparam int unsigned DB = 0;
`endif
  localparam int unsigned LAT  = 3 + DB;
  localparam int unsigned HOLD = DB + 2;
  localparam int unsigned WIN  = LAT + HOLD + DB + 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] din;
  logic       en;
  logic       load;
  logic [7:0] dout;
  logic       valid;
  logic [7:0] segments;
  logic [3:0] anodes;

  int n_checks = 0;
  int n_fail   = 0;
  int m_code   = 0;
  int m_count  = 0;
  logic [7:0] segtab [10];

  decoder_3to8_scan #(.REFRESH_DIV(RDIV), .DEBOUNCE_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .din(din), .en(en), .load(load),
    .dout(dout), .valid(valid), .segments(segments), .anodes(anodes)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] anode_of(input int idx);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << idx);
  endfunction

  function automatic logic [7:0] exp_seg(input int idx);
    case (idx)
      0:       return segtab[m_code];
      1:       return 8'hFF;
      2:       return segtab[m_count % 10];
      default: return segtab[m_count / 10];
    endcase
  endfunction

  // Waits (bounded) until digit idx is lit; returns X on timeout so the caller's check fails
  task automatic read_digit(input int idx, output logic [7:0] seg);
    seg = 8'hxx;
    for (int i = 0; i < 4 * RDIV + 4; i++) begin
      if (anodes === anode_of(idx)) begin
        seg = segments;
        return;
      end
      @(negedge clk);
    end
  endtask

  // Press starting at a negedge; counts valid pulses and records the first one
  task automatic do_press(input logic [2:0] d, output int npulse, output int first_k);
    npulse  = 0;
    first_k = 0;
    din  = d;
    load = 1'b1;
    for (int k = 1; k <= int'(WIN); k++) begin
      @(negedge clk);
      if (k == int'(HOLD)) load = 1'b0;
      if (valid === 1'b1) begin
        npulse++;
        if (first_k == 0) first_k = k;
      end
    end
    if (en) begin
      m_code  = int'(d);
      m_count = (m_count + 1) % 100;
    end
  endtask

  task automatic test_reset();
    int idx;
    rst = 1'b1; load = 1'b0; en = 1'b1; din = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_code = 0; m_count = 0;
    n_checks++;
    if (dout !== 8'h00 || valid !== 1'b0 || anodes !== 4'b1110 || segments !== 8'hC0) begin
      n_fail++;
      $display("FAIL reset_state dout=%h valid=%b anodes=%b seg=%h, want 00 0 1110 C0",
               dout, valid, anodes, segments);
    end
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      idx = (k / int'(RDIV)) % 4;
      n_checks++;
      if (anodes !== anode_of(idx) || segments !== exp_seg(idx)) begin
        n_fail++;
        $display("FAIL scan_step k=%0d anodes=%b seg=%h, want %b %h",
                 k, anodes, segments, anode_of(idx), exp_seg(idx));
      end
    end
  endtask

  task automatic test_decode_sweep();
    int np, fk;
    logic [7:0] s;
    logic [2:0] d;
    en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      d = (i < 8) ? 3'(i) : 3'($urandom_range(0, 7));
      do_press(d, np, fk);
      n_checks++;
      if (np != 1 || fk != int'(LAT) || dout !== 8'(1 << d)) begin
        n_fail++;
        $display("FAIL decode d=%0d pulses=%0d at=%0d dout=%h, want 1 %0d %h",
                 d, np, fk, dout, LAT, 8'(1 << d));
      end
      if (d == 3'd1 || d == 3'd7 || i >= 8) begin
        read_digit(0, s);
        n_checks++;
        if (s !== exp_seg(0)) begin
          n_fail++;
          $display("FAIL digit0 d=%0d seg=%h, want %h", d, s, exp_seg(0));
        end
      end
    end
    read_digit(2, s);
    n_checks++;
    if (s !== exp_seg(2)) begin
      n_fail++;
      $display("FAIL sweep_ones seg=%h, want %h", s, exp_seg(2));
    end
  endtask

  task automatic test_disable();
    int np, fk;
    logic [7:0] s;
    en = 1'b1;
    do_press(3'd3, np, fk);
    en = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dout !== 8'h00) begin
      n_fail++;
      $display("FAIL disable_dout dout=%h, want 00", dout);
    end
    do_press(3'd5, np, fk);
    n_checks++;
    if (np != 0 || dout !== 8'h00) begin
      n_fail++;
      $display("FAIL disable_press pulses=%0d dout=%h, want 0 00", np, dout);
    end
    for (int idx = 0; idx < 4; idx += 2) begin
      read_digit(idx, s);
      n_checks++;
      if (s !== exp_seg(idx)) begin
        n_fail++;
        $display("FAIL disable_hold digit%0d seg=%h, want %h", idx, s, exp_seg(idx));
      end
    end
    en = 1'b1;
    @(negedge clk);
    n_checks++;
    if (dout !== 8'h08) begin
      n_fail++;
      $display("FAIL enable_restore dout=%h, want 08", dout);
    end
  endtask

  task automatic test_held();
    int np;
    logic [7:0] s;
    np = 0;
    en = 1'b1;
    din = 3'($urandom_range(0, 7));
    load = 1'b1;
    for (int k = 1; k <= 50 + int'(LAT + 2 * DB) + 4; k++) begin
      @(negedge clk);
      if (k == 50) load = 1'b0;
      if (valid === 1'b1) np++;
    end
    m_code = int'(din);
    m_count = (m_count + 1) % 100;
    n_checks++;
    if (np != 1) begin
      n_fail++;
      $display("FAIL held_pulses got %0d, want 1", np);
    end
    read_digit(2, s);
    n_checks++;
    if (s !== exp_seg(2)) begin
      n_fail++;
      $display("FAIL held_count ones seg=%h, want %h", s, exp_seg(2));
    end
  endtask

  task automatic test_async_reset();
    int np;
    np = 0;
    en = 1'b1;
    din = 3'd6;
    load = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    load = 1'b0;
    #1;
    n_checks++;
    if (dout !== 8'h00 || valid !== 1'b0 || anodes !== 4'b1110 || segments !== 8'hC0) begin
      n_fail++;
      $display("FAIL async_reset dout=%h valid=%b anodes=%b seg=%h, want 00 0 1110 C0",
               dout, valid, anodes, segments);
    end
    @(negedge clk);
    rst = 1'b0;
    m_code = 0; m_count = 0;
    for (int k = 0; k < int'(WIN); k++) begin
      @(negedge clk);
      if (valid === 1'b1) np++;
    end
    n_checks++;
    if (np != 0 || dout !== 8'h01) begin
      n_fail++;
      $display("FAIL post_reset pulses=%0d dout=%h, want 0 01", np, dout);
    end
  endtask

  task automatic test_wrap();
    int np, fk;
    logic [7:0] s2, s3;
    en = 1'b1;
    for (int i = 0; i < 99; i++) do_press(3'($urandom_range(0, 7)), np, fk);
    read_digit(2, s2);
    read_digit(3, s3);
    n_checks++;
    if (m_count != 99 || s2 !== 8'h90 || s3 !== 8'h90) begin
      n_fail++;
      $display("FAIL wrap_99 ones=%h tens=%h, want 90 90", s2, s3);
    end
    do_press(3'd2, np, fk);
    read_digit(2, s2);
    read_digit(3, s3);
    n_checks++;
    if (m_count != 0 || s2 !== 8'hC0 || s3 !== 8'hC0 || dout !== 8'h04) begin
      n_fail++;
      $display("FAIL wrap_00 ones=%h tens=%h dout=%h, want C0 C0 04", s2, s3, dout);
    end
  endtask

`ifdef DEBOUNCE_EN
  task automatic test_debounce();
    int np, fk;
    logic [7:0] s;
    np = 0; fk = 0;
    en = 1'b1;
    din = 3'd4;
    load = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 5) load = 1'b0;
      if (valid === 1'b1) np++;
    end
    read_digit(2, s);
    n_checks++;
    if (np != 0 || s !== exp_seg(2)) begin
      n_fail++;
      $display("FAIL glitch pulses=%0d ones=%h, want 0 %h", np, s, exp_seg(2));
    end
    load = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k == 20) load = 1'b0;
      if (valid === 1'b1) begin
        np++;
        if (fk == 0) fk = k;
      end
    end
    m_code = 4;
    m_count = (m_count + 1) % 100;
    n_checks++;
    if (np != 1 || fk != 11 || dout !== 8'h10) begin
      n_fail++;
      $display("FAIL debounce_press pulses=%0d at=%0d dout=%h, want 1 11 10", np, fk, dout);
    end
  endtask
`endif

  initial begin
    segtab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    rst = 1'b1; load = 1'b0; en = 1'b1; din = '0;
    @(negedge clk);
    test_reset();
    test_decode_sweep();
    test_disable();
    test_held();
`ifdef DEBOUNCE_EN
    test_debounce();
`endif
    test_async_reset();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
